// File: rtl/axi4lite_initiator_pkg.sv
// Shared types for the AXI4-Lite initiator: FSM state encoding and AXI response codes.
package axi4lite_initiator_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWr    = 3'd1,
    StWrB   = 3'd2,
    StRdAr  = 3'd3,
    StRdR   = 3'd4,
    StDrain = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4lite_initiator.sv
// Single-outstanding AXI4-Lite initiator: command port in, AXI4-Lite out, with a watchdog
// that aborts a transaction whose slave never answers.
module axi4lite_initiator
  import axi4lite_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        resp_timeout_o,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  input  logic        outport_awready_i,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  input  logic        outport_wready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  output logic        outport_bready_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  output logic        outport_rready_o
);

  localparam int unsigned WdogW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [WdogW-1:0] WdogLimit =
      WdogW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              is_write_q, is_write_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              resp_timeout_q, resp_timeout_d;

  logic busy, expire;

  assign busy = (state_q == StWr) || (state_q == StWrB) || (state_q == StRdAr) ||
                (state_q == StRdR);
  // Counter reaches TIMEOUT_CYCLES at the end of this busy cycle.
  assign expire = TimeoutEn && busy && (wdog_q == WdogLimit);

  assign req_ready_o       = (state_q == StIdle) && !resp_valid_q;
  assign outport_awvalid_o = awvalid_q;
  assign outport_awaddr_o  = addr_q;
  assign outport_wvalid_o  = wvalid_q;
  assign outport_wdata_o   = wdata_q;
  assign outport_wstrb_o   = wstrb_q;
  assign outport_arvalid_o = arvalid_q;
  assign outport_araddr_o  = addr_q;
  assign outport_bready_o  = (state_q == StWrB) || ((state_q == StDrain) && is_write_q);
  assign outport_rready_o  = (state_q == StRdR) || ((state_q == StDrain) && !is_write_q);
  assign resp_valid_o      = resp_valid_q;
  assign resp_rdata_o      = resp_rdata_q;
  assign resp_err_o        = resp_err_q;
  assign resp_timeout_o    = resp_timeout_q;

  always_comb begin
    state_d        = state_q;
    awvalid_d      = awvalid_q && !outport_awready_i;
    wvalid_d       = wvalid_q && !outport_wready_i;
    arvalid_d      = arvalid_q && !outport_arready_i;
    is_write_d     = is_write_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    wdog_d         = (busy && (wdog_q != '1)) ? wdog_q + 1'b1 : wdog_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = '0;
    resp_err_d     = 1'b0;
    resp_timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_o) begin
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          wstrb_d    = req_wstrb_i;
          is_write_d = req_write_i;
          wdog_d     = '0;
          if (req_write_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWr;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdAr;
          end
        end
      end
      StWr: begin
        if (expire) begin
          state_d = StDrain;
        end else if (!awvalid_d && !wvalid_d) begin
          state_d = StWrB;
        end
      end
      StWrB: begin
        if (outport_bvalid_i) begin
          resp_valid_d = 1'b1;
          resp_err_d   = resp_is_err(outport_bresp_i);
          state_d      = StIdle;
        end else if (expire) begin
          state_d = StDrain;
        end
      end
      StRdAr: begin
        if (expire) begin
          state_d = StDrain;
        end else if (!arvalid_d) begin
          state_d = StRdR;
        end
      end
      StRdR: begin
        if (outport_rvalid_i) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = outport_rdata_i;
          resp_err_d   = resp_is_err(outport_rresp_i);
          state_d      = StIdle;
        end else if (expire) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Late response is swallowed; nothing reaches the command port.
        if ((is_write_q && outport_bvalid_i) || (!is_write_q && outport_rvalid_i)) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          arvalid_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StDrain && state_q != StDrain) begin
      resp_valid_d   = 1'b1;
      resp_err_d     = 1'b1;
      resp_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      is_write_q     <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      wdog_q         <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      arvalid_q      <= arvalid_d;
      is_write_q     <= is_write_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      wdog_q         <= wdog_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_initiator.sv
// Directed bench for axi4lite_initiator against a behavioural AXI4-Lite slave with stall knobs.
module tb_axi4lite_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err, resp_timeout;
  logic [31:0] resp_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi4lite_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .resp_timeout_o(resp_timeout),
    .outport_awvalid_o(awvalid), .outport_awaddr_o(awaddr), .outport_awready_i(awready),
    .outport_wvalid_o(wvalid), .outport_wdata_o(wdata), .outport_wstrb_o(wstrb),
    .outport_wready_i(wready),
    .outport_bvalid_i(bvalid), .outport_bresp_i(bresp), .outport_bready_o(bready),
    .outport_arvalid_o(arvalid), .outport_araddr_o(araddr), .outport_arready_i(arready),
    .outport_rvalid_i(rvalid), .outport_rdata_i(rdata), .outport_rresp_i(rresp),
    .outport_rready_o(rready)
  );

  // Slave model knobs, driven from the stimulus block.
  int          aw_stall, w_stall, ar_stall, b_stall, r_stall;
  bit          ar_never, rdata_force;
  logic [31:0] rdata_force_val;
  logic [1:0]  bresp_cfg, rresp_cfg;

  int          aw_wait, w_wait, ar_wait, b_timer, r_timer;
  int          aw_beats, w_beats, ar_beats, b_beats, r_beats;
  bit          aw_got, w_got;
  logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
  logic [3:0]  w_strb_l;
  logic [31:0] slv_mem [16];

  logic        aw_hs, w_hs, aw_done_now, w_done_now;
  logic [31:0] wr_addr_now, wr_data_now;
  logic [3:0]  wr_strb_now;

  assign awready     = awvalid && (aw_wait >= aw_stall);
  assign wready      = wvalid && (w_wait >= w_stall);
  assign arready     = arvalid && !ar_never && (ar_wait >= ar_stall);
  assign bvalid      = (b_timer == 0);
  assign rvalid      = (r_timer == 0);
  assign bresp       = bresp_cfg;
  assign rresp       = rresp_cfg;
  assign rdata       = rdata_force ? rdata_force_val : slv_mem[ar_addr_l[5:2]];
  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign aw_done_now = aw_got || aw_hs;
  assign w_done_now  = w_got || w_hs;
  assign wr_addr_now = aw_got ? aw_addr_l : awaddr;
  assign wr_data_now = w_got ? w_data_l : wdata;
  assign wr_strb_now = w_got ? w_strb_l : wstrb;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_timer <= -1; r_timer <= -1;
      aw_beats <= 0; w_beats <= 0; ar_beats <= 0; b_beats <= 0; r_beats <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0; ar_addr_l <= '0;
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
    end else begin
      if (aw_hs) begin aw_wait <= 0; aw_beats <= aw_beats + 1; aw_addr_l <= awaddr; end
      else if (awvalid) aw_wait <= aw_wait + 1;
      if (w_hs) begin
        w_wait <= 0; w_beats <= w_beats + 1; w_data_l <= wdata; w_strb_l <= wstrb;
      end else if (wvalid) w_wait <= w_wait + 1;
      if (aw_done_now && w_done_now && (aw_hs || w_hs)) begin
        for (int b = 0; b < 4; b++)
          if (wr_strb_now[b]) slv_mem[wr_addr_now[5:2]][8*b +: 8] <= wr_data_now[8*b +: 8];
        b_timer <= b_stall;
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
        if (bvalid && bready) begin b_timer <= -1; b_beats <= b_beats + 1; end
        else if (b_timer > 0) b_timer <= b_timer - 1;
      end
      if (arvalid && arready) begin
        ar_wait <= 0; ar_beats <= ar_beats + 1; ar_addr_l <= araddr; r_timer <= r_stall;
      end else begin
        if (arvalid) ar_wait <= ar_wait + 1;
        if (rvalid && rready) begin r_timer <= -1; r_beats <= r_beats + 1; end
        else if (r_timer > 0) r_timer <= r_timer - 1;
      end
    end
  end

  int          vecs = 0;
  int          miscompares = 0;
  logic [31:0] exp_mem [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Leaves the caller at the first negedge after the accepting edge (cycle 1).
  task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = strb;
    while (!req_ready && n < 32) begin @(negedge clk); n++; end
    chk("req_accepted", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int start, output int lat, output bit got);
    lat = start;
    while (!resp_valid && lat < 64) begin @(negedge clk); lat++; end
    got = resp_valid;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: observed no finish, required finish");
    $fatal(1);
  end

  initial begin
    int lat, nresp, pulses, idx;
    bit got, wr;
    logic [31:0] d;
    logic [3:0]  s;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0;
    aw_stall = 0; w_stall = 0; ar_stall = 0; b_stall = 0; r_stall = 0;
    ar_never = 1'b0; rdata_force = 1'b0; rdata_force_val = '0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_awaddr", awaddr, 32'h0);
    rst = 1'b0;

    // 1: zero-wait write
    start_req(1'b1, 32'h9200_0004, 32'h1234_5678, 4'hF);
    wait_resp(1, lat, got);
    chk("t1_latency", lat, 32'd3);
    chk("t1_err", 32'(resp_err), 32'd0);
    chk("t1_rdata", resp_rdata, 32'h0);
    chk("t1_timeout", 32'(resp_timeout), 32'd0);
    chk("t1_aw_beats", aw_beats, 32'd1);
    chk("t1_w_beats", w_beats, 32'd1);
    chk("t1_awaddr", aw_addr_l, 32'h9200_0004);
    chk("t1_mem", slv_mem[1], 32'h1234_5678);
    @(negedge clk);
    chk("t1_ready_after", 32'(req_ready), 32'd1);

    // 2: W accepted four cycles before AW
    aw_stall = 4;
    start_req(1'b1, 32'h9200_0008, 32'hA5A5_BEEF, 4'b1100);
    chk("t2_c1_awvalid", 32'(awvalid), 32'd1);
    chk("t2_c1_wvalid", 32'(wvalid), 32'd1);
    @(negedge clk);
    chk("t2_c2_wvalid_dropped", 32'(wvalid), 32'd0);
    chk("t2_c2_awvalid_held", 32'(awvalid), 32'd1);
    wait_resp(2, lat, got);
    chk("t2_latency", lat, 32'd7);
    chk("t2_err", 32'(resp_err), 32'd0);
    chk("t2_b_beats", b_beats, 32'd2);
    chk("t2_w_beats", w_beats, 32'd2);
    chk("t2_mem", slv_mem[2], 32'hA5A5_0000);
    aw_stall = 0;

    // 3: read with SLVERR
    rdata_force = 1'b1; rdata_force_val = 32'hCAFE_F00D; rresp_cfg = 2'b10;
    start_req(1'b0, 32'h9200_0000, 32'h0, 4'h0);
    wait_resp(1, lat, got);
    chk("t3_latency", lat, 32'd3);
    chk("t3_rdata", resp_rdata, 32'hCAFE_F00D);
    chk("t3_err", 32'(resp_err), 32'd1);
    chk("t3_timeout", 32'(resp_timeout), 32'd0);
    rdata_force = 1'b0; rresp_cfg = 2'b00;

    // 4: watchdog on a read whose AR is never accepted; pulse follows 16 busy cycles
    ar_never = 1'b1;
    start_req(1'b0, 32'h9200_000C, 32'h0, 4'h0);
    wait_resp(1, lat, got);
    chk("t4_latency", lat, 32'd17);
    chk("t4_err", 32'(resp_err), 32'd1);
    chk("t4_timeout", 32'(resp_timeout), 32'd1);
    chk("t4_rdata", resp_rdata, 32'h0);
    chk("t4_arvalid_held", 32'(arvalid), 32'd1);
    chk("t4_ready_low", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_arvalid_still", 32'(arvalid), 32'd1);
    chk("t4_rready_drain", 32'(rready), 32'd1);
    ar_never = 1'b0;
    pulses = 0;
    for (int n = 0; n < 20 && !req_ready; n++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("t4_no_second_pulse", pulses, 32'd0);
    chk("t4_ready_back", 32'(req_ready), 32'd1);
    chk("t4_arvalid_off", 32'(arvalid), 32'd0);
    chk("t4_r_absorbed", r_beats, 32'd2);

    // 5: reset while waiting in WR_B
    b_stall = 5;
    start_req(1'b1, 32'h9200_0010, 32'h0BAD_0BAD, 4'hF);
    @(negedge clk);
    chk("t5_in_wrb_bready", 32'(bready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_awvalid", 32'(awvalid), 32'd0);
    chk("t5_wvalid", 32'(wvalid), 32'd0);
    chk("t5_arvalid", 32'(arvalid), 32'd0);
    chk("t5_bready", 32'(bready), 32'd0);
    chk("t5_rready", 32'(rready), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd1);
    chk("t5_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    b_stall = 0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    pulses = 0;
    repeat (8) begin @(negedge clk); if (resp_valid) pulses++; end
    chk("t5_no_pulse", pulses, 32'd0);

    // 6: back-to-back commands with random slave stalls
    nresp = 0;
    for (int i = 0; i < 10; i++) begin
      aw_stall = $urandom_range(0, 3); w_stall = $urandom_range(0, 3);
      ar_stall = $urandom_range(0, 3); b_stall = $urandom_range(0, 3);
      r_stall  = $urandom_range(0, 3);
      wr  = (i < 3) ? 1'b1 : 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 3);
      d   = $urandom;
      s   = 4'($urandom_range(1, 15));
      start_req(wr, 32'h9200_0000 + 32'(idx * 4), d, s);
      wait_resp(1, lat, got);
      chk($sformatf("t6_%0d_got", i), 32'(got), 32'd1);
      nresp += int'(got);
      if (wr) begin
        exp_mem[idx] = merge(exp_mem[idx], d, s);
        chk($sformatf("t6_%0d_wr_rdata", i), resp_rdata, 32'h0);
      end else begin
        chk($sformatf("t6_%0d_rd_rdata", i), resp_rdata, exp_mem[idx]);
      end
      chk($sformatf("t6_%0d_err", i), 32'(resp_err), 32'd0);
      chk($sformatf("t6_%0d_timeout", i), 32'(resp_timeout), 32'd0);
    end
    chk("t6_resp_count", nresp, 32'd10);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_mem_%0d", i), slv_mem[i], exp_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
